// File: rtl/dmem_wait_responder.sv
// Word-addressed data-memory responder with a fixed number of wait states.
// Serves one load or store at a time over a valid/ready request/response pair.
module dmem_wait_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        lat_write;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  // Not reset: contents are preloaded from outside and survive reset.
  logic [31:0] memory [DEPTH];

  logic          access;
  logic          addr_err;
  logic [AW-1:0] idx;

  assign idx      = lat_addr[AW+1:2];
  // Word address compared in full width so any upper address bit faults.
  assign addr_err = (lat_addr[1:0] != 2'b00) ||
                    ({2'b00, lat_addr[31:2]} >= 32'(DEPTH));
  // Access happens on the last BUSY edge, same edge that enters RESP.
  assign access   = (state == BUSY) && (cnt == 4'd0);

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);

  // Next-state logic for the request/wait/response sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid)     state_nxt = BUSY;
      BUSY:    if (cnt == 4'd0)   state_nxt = RESP;
      RESP:    if (resp_ready)    state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // State, wait counter, latched request and response registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      lat_write  <= 1'b0;
      lat_addr   <= 32'd0;
      lat_wdata  <= 32'd0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_valid) begin
        cnt       <= 4'(WAIT_CYCLES);
        lat_write <= req_write;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
      end else if (state == BUSY && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (access) begin
        resp_err   <= addr_err;
        resp_rdata <= (addr_err || lat_write) ? 32'd0 : memory[idx];
      end
    end
  end

  // Store port; an aborted access never reaches here since reset forces IDLE.
  always_ff @(posedge clk) begin
    if (access && !addr_err && lat_write)
      memory[idx] <= lat_wdata;
  end

endmodule

// File: doc/dmem_wait_responder.md
Name: dmem_wait_responder

Overview:
Word-addressed data-memory responder for the CPU's load/store path. It sits on the slave side of a valid/ready request/response handshake and serves one 32-bit load or store at a time. Each access takes a programmable number of wait states. It is the memory end that a multi-cycle or pipelined CPU core drives, replacing the zero-latency data memory.

Parameters:
DEPTH, 256, number of 32-bit words in internal storage; power of two, minimum 4.
WAIT_CYCLES, 2, extra wait-state cycles per access; range 0..15.

Ports:
clk  input  1  clock; all state updates on posedge.
reset  input  1  asynchronous, active-low reset; 0 = in reset.
req_valid  input  1  initiator presents a request.
req_ready  output  1  responder can accept a request this cycle.
req_write  input  1  1 = store, 0 = load.
req_addr  input  32  byte address.
req_wdata  input  32  store data.
resp_valid  output  1  response available.
resp_ready  input  1  initiator consumes the response.
resp_rdata  output  32  load data; 0 for stores and errors.
resp_err  output  1  access was misaligned or out of range.

Behaviour:
- Storage: array named memory, DEPTH x 32.
  - Not cleared by reset; the testbench preloads it hierarchically.
  - Word index is req_addr[log2(DEPTH)+1:2].
- States: IDLE, BUSY, RESP.
- req_ready = (state == IDLE), combinational. resp_valid = (state == RESP).
- Reset asserted (reset == 0), asynchronously:
  - state = IDLE; wait counter = 0.
  - resp_rdata = 0; resp_err = 0; latched request fields cleared.
  - Resulting outputs: req_ready = 1, resp_valid = 0.
- IDLE: at a posedge with req_valid = 1:
  - Latch req_write, req_addr and req_wdata.
  - Load the counter with WAIT_CYCLES and go to BUSY.
  - req_valid = 0: stay in IDLE.
- BUSY: at each posedge:
  - If counter != 0: decrement it.
  - If counter == 0: perform the access and go to RESP.
    - Error check: error if addr[1:0] != 0, or addr >> 2 >= DEPTH (also covers upper address bits set above the index).
    - Error: no write; resp_rdata = 0; resp_err = 1.
    - Store, no error: memory[idx] <= wdata; resp_rdata = 0; resp_err = 0.
    - Load, no error: resp_rdata = memory[idx]; resp_err = 0.
- Latency: a request accepted at posedge N gives resp_valid = 1 after posedge N+1+WAIT_CYCLES. The store takes effect at that same edge.
- RESP: resp_rdata and resp_err stay stable while resp_valid = 1.
  - At a posedge with resp_ready = 1: go to IDLE. resp_rdata and resp_err keep their values (don't-care once resp_valid = 0).
  - resp_ready = 0: hold indefinitely (backpressure).
- No request is accepted while in BUSY or RESP. req_valid, address and data are ignored there; the initiator must hold them until req_ready.
- Back-to-back: a response consumed at edge M allows a new accept no earlier than edge M+1. Peak throughput is one access per WAIT_CYCLES+3 cycles.
- Reset mid-operation:
  - Reset during BUSY aborts the access; memory is unchanged.
  - Reset during RESP drops the response; a store that already completed stays written.
- Load-after-store to the same word returns the new data.
- resp_ready while in IDLE or BUSY is ignored.
- Counter width is 4 bits; no wrap, because it only decrements from WAIT_CYCLES to 0.

Test Plan:
- Reset/idle: reset = 0 mid-simulation. Required: req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0 immediately, without waiting for a clock edge.
- Store then load, WAIT_CYCLES = 2:
  - Store 0xDEADBEEF to address 0x10, then load 0x10.
  - Required: each resp_valid appears 3 edges after accept; load resp_rdata = 0xDEADBEEF; resp_err = 0; memory[4] = 0xDEADBEEF.
- Backpressure:
  - Preload memory[1] = 50; load 0x4; hold resp_ready = 0 for 5 cycles.
  - Required: resp_valid stays 1 with rdata 50 throughout; req_ready = 0 even with a second req_valid asserted; IDLE one edge after resp_ready = 1.
- Errors:
  - Store 0x12345678 to 0x6 (misaligned) -> resp_err = 1, rdata 0, memory[1] unchanged.
  - Load 0x400 with DEPTH = 256 -> resp_err = 1, rdata 0.
- Reset mid-BUSY: store 0xA5A5A5A5 to 0x8; deassert-assert reset one cycle after accept. Required: memory[2] keeps its old value; state IDLE; resp_valid never pulses.
- WAIT_CYCLES = 0 instance: load 0x0 with memory[0] = 7. Required: resp_valid after accept edge +1, rdata 7; with resp_ready tied to 1, a new accept is possible 3 cycles apart.
